// File: rtl/aes128_cipher_datapath.sv
// ---------------------------------------------------------------------------
// aes128_cipher_datapath
//
// Iterative AES-128 encryption datapath that consumes round keys from an
// external key scheduler. A plaintext block is accepted over a valid/ready
// handshake. KS_EN is pulsed so the scheduler loads K0 on the acceptance
// edge. The block then runs one round per clock: the initial AddRoundKey,
// nine full rounds, and a final round without MixColumns. The ciphertext is
// held under a valid/ready handshake until the consumer takes it.
//
// Ports:
//   CLK          clock, rising-edge active
//   RST          asynchronous active-high reset
//   IN_VALID     plaintext valid
//   IN_READY     datapath can accept plaintext (IDLE, not in reset)
//   PLAIN_TEXT   128-bit plaintext, bits [127:120] = state byte 0
//   KS_EN        single-cycle enable to the key scheduler (handshake pulse)
//   ROUND_KEY    round key presented by the key scheduler this cycle
//   OUT_VALID    ciphertext valid
//   OUT_READY    downstream accepts ciphertext
//   CIPHER_TEXT  ciphertext (the state register itself)
// ---------------------------------------------------------------------------

// AES forward S-box, one byte lane, purely combinational table lookup.
module aes128_sbox (
    input  logic [7:0] lane,
    output logic [7:0] subst
);
    // Row-major FIPS-197 S-box; entry x sits at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x starts at bit 8*(255-x); (255-x) is simply ~x for a byte.
    assign subst = SBOX_TABLE[{~lane, 3'b000} +: 8];
endmodule

module aes128_cipher_datapath #(
    parameter int DATA_LENGTH = 128,
    parameter int NUM_ROUNDS  = 10,
    parameter int BYTE_LENGTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [DATA_LENGTH-1:0] PLAIN_TEXT,
    output logic                   KS_EN,
    input  logic [DATA_LENGTH-1:0] ROUND_KEY,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [DATA_LENGTH-1:0] CIPHER_TEXT
);
    localparam int         NUM_BYTES  = DATA_LENGTH / BYTE_LENGTH;
    localparam int         NUM_COLS   = NUM_BYTES / 4;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t                   fsm_state_r;
    fsm_t                   fsm_next_s;
    logic [DATA_LENGTH-1:0] state_reg_r;
    logic [3:0]             round_cnt_r;
    logic                   out_valid_r;
    logic                   in_ready_s;
    logic                   ks_en_s;
    logic [DATA_LENGTH-1:0] sub_bytes_s;
    logic [DATA_LENGTH-1:0] shift_rows_s;
    logic [DATA_LENGTH-1:0] mix_cols_s;
    logic [DATA_LENGTH-1:0] round_out_s;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [BYTE_LENGTH-1:0] xtime(input logic [BYTE_LENGTH-1:0] b);
        logic [BYTE_LENGTH-1:0] shifted;
        shifted = {b[BYTE_LENGTH-2:0], 1'b0};
        if (b[BYTE_LENGTH-1]) begin
            return shifted ^ 8'h1b;
        end else begin
            return shifted;
        end
    endfunction

    // One MixColumns column, matrix rows [2 3 1 1] rotated; s0 is the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] t0, t1, t2, t3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        t0 = xtime(s0) ^ (xtime(s1) ^ s1) ^ s2 ^ s3;
        t1 = s0 ^ xtime(s1) ^ (xtime(s2) ^ s2) ^ s3;
        t2 = s0 ^ s1 ^ xtime(s2) ^ (xtime(s3) ^ s3);
        t3 = (xtime(s0) ^ s0) ^ s1 ^ s2 ^ xtime(s3);
        return {t0, t1, t2, t3};
    endfunction

    // SubBytes: one S-box per state byte.
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_sbox
        aes128_sbox u_sbox (
            .lane  (state_reg_r[DATA_LENGTH-1-BYTE_LENGTH*i -: BYTE_LENGTH]),
            .subst (sub_bytes_s[DATA_LENGTH-1-BYTE_LENGTH*i -: BYTE_LENGTH])
        );
    end

    // ShiftRows: byte (row r, col c) takes the byte from (row r, col c+r mod 4).
    // State byte index is 4*col + row (column-major).
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign shift_rows_s[DATA_LENGTH-1-BYTE_LENGTH*(4*c+r) -: BYTE_LENGTH] =
                sub_bytes_s[DATA_LENGTH-1-BYTE_LENGTH*(4*((c+r)%NUM_COLS)+r) -: BYTE_LENGTH];
        end
    end

    // MixColumns on each 32-bit column of the shifted state.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_mix
        assign mix_cols_s[DATA_LENGTH-1-32*c -: 32] = mix_column(shift_rows_s[DATA_LENGTH-1-32*c -: 32]);
    end

    // Round function select: initial AddRoundKey, full round, or final round.
    always_comb begin
        round_out_s = state_reg_r ^ ROUND_KEY;
        if (round_cnt_r == 4'd0) begin
            round_out_s = state_reg_r ^ ROUND_KEY;
        end else if (round_cnt_r == LAST_ROUND) begin
            round_out_s = shift_rows_s ^ ROUND_KEY;
        end else begin
            round_out_s = mix_cols_s ^ ROUND_KEY;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fsm_state_r <= IDLE;
        end else begin
            fsm_state_r <= fsm_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        fsm_next_s = fsm_state_r;
        case (fsm_state_r)
            IDLE: begin
                if (ks_en_s) begin
                    fsm_next_s = ROUND;
                end else begin
                    fsm_next_s = IDLE;
                end
            end
            ROUND: begin
                if (round_cnt_r == LAST_ROUND) begin
                    fsm_next_s = DONE;
                end else begin
                    fsm_next_s = ROUND;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    fsm_next_s = IDLE;
                end else begin
                    fsm_next_s = DONE;
                end
            end
            default: fsm_next_s = IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE and never while reset is asserted, so the
    // scheduler enable cannot fire during reset or while a block is in flight.
    always_comb begin
        in_ready_s = 1'b0;
        case (fsm_state_r)
            IDLE:    in_ready_s = ~RST;
            ROUND:   in_ready_s = 1'b0;
            DONE:    in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
        ks_en_s = IN_VALID & in_ready_s;
    end

    // Datapath state, round counter and output-valid register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg_r <= {DATA_LENGTH{1'b0}};
            round_cnt_r <= 4'd0;
            out_valid_r <= 1'b0;
        end else begin
            case (fsm_state_r)
                IDLE: begin
                    if (ks_en_s) begin
                        state_reg_r <= PLAIN_TEXT;
                        round_cnt_r <= 4'd0;
                    end
                end
                ROUND: begin
                    state_reg_r <= round_out_s;
                    if (round_cnt_r == LAST_ROUND) begin
                        round_cnt_r <= 4'd0;
                        out_valid_r <= 1'b1;
                    end else begin
                        round_cnt_r <= round_cnt_r + 4'd1;
                    end
                end
                DONE: begin
                    // Ciphertext is frozen here; only the handshake clears valid.
                    if (OUT_READY) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    round_cnt_r <= 4'd0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY    = in_ready_s;
    assign KS_EN       = ks_en_s;
    assign OUT_VALID   = out_valid_r;
    assign CIPHER_TEXT = state_reg_r;

endmodule

// File: doc/aes128_cipher_datapath.md
Name: aes128_cipher_datapath

Overview:
- Consumer of the round keys from the AES-128 key scheduler.
- Accepts one 128-bit plaintext block over a valid/ready handshake and pulses the scheduler's enable.
- Applies the initial AddRoundKey and then 10 iterative rounds, one per clock, using the round key the scheduler presents each cycle.
- Holds the ciphertext under a valid/ready output handshake until it is taken.

Parameters:
- DATA_LENGTH, 128, block and round-key width; only 128 supported.
- NUM_ROUNDS, 10, AES-128 round count; the final round omits MixColumns.
- BYTE_LENGTH, 8, S-box and byte-lane width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  plaintext valid.
- IN_READY  out  1  block can accept plaintext.
- PLAIN_TEXT  in  128  plaintext; bits [127:120] are state byte 0 (FIPS-197 column-major order).
- KS_EN  out  1  enable pulse to the key scheduler's En input.
- ROUND_KEY  in  128  current round key from the key scheduler's subkey output.
- OUT_VALID  out  1  ciphertext valid.
- OUT_READY  in  1  downstream accepts ciphertext.
- CIPHER_TEXT  out  128  ciphertext (the state register).

Behaviour:
- Reset (RST high, async) clears all registers and outputs:
  - FSM = IDLE, STATE_REG = 0, ROUND_CNT = 0.
  - OUT_VALID = 0, KS_EN = 0, CIPHER_TEXT = 0.
  - IN_READY is forced 0 while RST is high.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - IN_READY = 1.
  - KS_EN = IN_VALID & IN_READY, combinational, a single cycle.
  - On the handshake edge A: STATE_REG <= PLAIN_TEXT, ROUND_CNT <= 0, go to ROUND.
- ROUND:
  - IN_READY = 0; IN_VALID is ignored.
  - Key contract: ROUND_KEY = K_r in the cycle after edge A+r, for r = 0..10. The key scheduler loads K0 on the same edge A that samples KS_EN.
  - ROUND_CNT = 0: STATE_REG <= STATE_REG ^ ROUND_KEY (initial AddRoundKey).
  - ROUND_CNT = 1..9: STATE_REG <= MixColumns(ShiftRows(SubBytes(STATE_REG))) ^ ROUND_KEY.
  - ROUND_CNT = 10: STATE_REG <= ShiftRows(SubBytes(STATE_REG)) ^ ROUND_KEY, then go to DONE.
  - ROUND_CNT increments every cycle and is 4 bits wide. It never exceeds 10; it clears to 0 on entry to DONE.
- Datapath:
  - SubBytes: 16 combinational S_box instances.
  - ShiftRows: row r rotated left by r bytes.
  - MixColumns: standard GF(2^8) matrix [2 3 1 1]; xtime is the left shift XOR 0x1B when the MSB is set.
- DONE:
  - OUT_VALID = 1; CIPHER_TEXT is stable.
  - On OUT_VALID & OUT_READY at an edge: go to IDLE, OUT_VALID <= 0. CIPHER_TEXT keeps the last value.
- Latency: OUT_VALID rises in the cycle after edge A+11, i.e. 11 cycles after acceptance.
- Throughput:
  - With OUT_READY held high, the earliest next acceptance is edge A+13.
  - The key scheduler's counter has returned to 0 by A+11, so KS_EN is never issued while it is busy.
- Backpressure: DONE is held indefinitely with OUT_READY low. No data loss; CIPHER_TEXT does not change.
- Reset mid-operation:
  - Immediate abort to IDLE with all registers cleared; no OUT_VALID is produced for the aborted block.
  - The system drives the same RST to the key scheduler, so both restart aligned.
- IN_VALID arriving in the same cycle as the DONE->IDLE transition: not accepted until IDLE is registered.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, PT 3243f6a8885a308d313198a2e0370734 -> after edge A+1 STATE_REG = 193de3bea0f4e22b9ac68d2ae9f84808. After A+11, OUT_VALID = 1 and CIPHER_TEXT = 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, PT 00112233445566778899aabbccddeeff -> CIPHER_TEXT = 69c4e0d86a7b0430d8cdb78070b4c55a; KS_EN high for exactly 1 cycle.
- Backpressure: OUT_READY low for 5 cycles after OUT_VALID -> OUT_VALID and CIPHER_TEXT stable, IN_READY = 0. Release -> return to IDLE next cycle.
- Busy rejection: IN_VALID held high with PT 0 during ROUND -> no KS_EN, no state change, and the first block's result is correct. The second block is accepted at A+13 and yields 66e94bd4ef8a2c3b884cfa59ca342b2e with key 0.
- Reset at ROUND_CNT = 5 -> outputs 0 and IDLE immediately. The App. B vector rerun afterwards gives 3925841d... .
- Back-to-back 3 blocks with OUT_READY tied high -> acceptances exactly 13 cycles apart, all three ciphertexts correct.
